// File: rtl/anc_ctrl_pkg.sv
// rtl/anc_ctrl_pkg.sv - shared state encoding, Q1.15 width and saturation helper for anc_ctrl
package anc_ctrl_pkg;

  localparam int SMP_W   = 16;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } anc_state_t;

  // Clamp a wide signed value into the Q1.15 range.
  function automatic logic signed [SMP_W-1:0] sat16(input logic signed [31:0] v);
    if (v > SAT_MAX) return SMP_W'(SAT_MAX);
    if (v < SAT_MIN) return SMP_W'(SAT_MIN);
    return v[SMP_W-1:0];
  endfunction

endpackage

// File: rtl/anc_sample_fifo.sv
// rtl/anc_sample_fifo.sv - show-ahead queue of {x, e} sample pairs
// Pointers carry one extra wrap bit so full and empty are distinguishable (FIFO_DEPTH >= 2).
module anc_sample_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/anc_ctrl.sv
// rtl/anc_ctrl.sv - LMS anti-noise sequencer: queues mic samples, issues FIR jobs, emits results
module anc_ctrl
  import anc_ctrl_pkg::*;
#(
  parameter int TAPS       = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 300
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    smp_valid,
  input  logic signed [SMP_W-1:0] x_smp,
  input  logic signed [SMP_W-1:0] e_smp,
  input  logic signed [SMP_W-1:0] mu,
  input  logic                    adapt_en,
  input  logic signed [SMP_W-1:0] a_bias,
  input  logic                    clr_err,
  output logic signed [SMP_W-1:0] fir_x_in,
  output logic signed [SMP_W-1:0] fir_a_in,
  output logic signed [SMP_W-1:0] fir_weight_adjust,
  output logic                    fir_go,
  input  logic                    fir_done,
  input  logic signed [SMP_W-1:0] fir_out_sample,
  input  logic                    fir_out_valid,
  output logic signed [SMP_W-1:0] y_out,
  output logic                    y_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  // A watchdog shorter than one full FIR pass could never see a completion.
  if (TIMEOUT <= TAPS) begin : g_bad_timeout
    $error("anc_ctrl: TIMEOUT must exceed TAPS");
  end

  anc_state_t         state;
  logic [CNT_W-1:0]   wd_cnt;
  logic [31:0]        head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               drop_evt;
  logic               to_evt;
  logic signed [SMP_W-1:0] head_x;
  logic signed [SMP_W-1:0] head_e;
  logic signed [31:0] prod;
  logic signed [31:0] neg_step;
  logic signed [SMP_W-1:0] adj;

  assign pop = (state == ISSUE);

  anc_sample_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (smp_valid),
    .wdata ({x_smp, e_smp}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_x = head[31:16];
  assign head_e = head[15:0];

  // The shifted product lies in [-32767, 32768], so negating it in 32 bits is exact.
  always_comb begin
    prod     = 32'(mu) * 32'(head_e);
    neg_step = -(prod >>> 15);
    adj      = adapt_en ? sat16(neg_step) : '0;
  end

  assign drop_evt = smp_valid && fifo_full && !pop;
  assign to_evt   = (state == WAIT) && !fir_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      fir_go            <= 1'b0;
      y_valid           <= 1'b0;
      wd_cnt            <= '0;
      fir_x_in          <= '0;
      fir_a_in          <= '0;
      fir_weight_adjust <= '0;
      y_out             <= '0;
    end else begin
      fir_go  <= 1'b0;
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state             <= ISSUE;
            busy              <= 1'b1;
            fir_go            <= 1'b1;
            fir_x_in          <= head_x;
            fir_a_in          <= a_bias;
            fir_weight_adjust <= adj;
          end
        end
        ISSUE: begin
          state  <= WAIT;
          wd_cnt <= WD_ONE;
        end
        WAIT: begin
          if (fir_done) begin
            if (fir_out_valid) begin
              state   <= EMIT;
              y_out   <= fir_out_sample;
              y_valid <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (wd_cnt == WD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
        end
        EMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (drop_evt)     overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (to_evt)       timeout <= 1'b1;
      else if (clr_err) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_anc_ctrl.sv
// tb/tb_anc_ctrl.sv - directed vector bench for anc_ctrl with a simple FIR responder
module tb_anc_ctrl;

  localparam int TIMEOUT = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smp_valid = 1'b0;
  logic [15:0] x_smp = '0;
  logic [15:0] e_smp = '0;
  logic [15:0] mu = '0;
  logic        adapt_en = 1'b0;
  logic [15:0] a_bias = '0;
  logic        clr_err = 1'b0;
  logic [15:0] fir_x_in;
  logic [15:0] fir_a_in;
  logic [15:0] fir_weight_adjust;
  logic        fir_go;
  logic        fir_done;
  logic [15:0] fir_out_sample;
  logic        fir_out_valid;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;
  logic        timeout;

  logic        mdl_en = 1'b0;
  int          fir_lat = 3;
  int          mdl_cnt = 0;
  logic        mdl_done = 1'b0;
  logic        mdl_valid = 1'b0;
  logic [15:0] mdl_sample = '0;
  logic        man_done = 1'b0;
  logic        man_valid = 1'b0;
  logic [15:0] man_sample = '0;

  int n_tests = 0;
  int n_fail = 0;

  assign fir_done       = mdl_done | man_done;
  assign fir_out_valid  = man_done ? man_valid : mdl_valid;
  assign fir_out_sample = man_done ? man_sample : mdl_sample;

  always #5 clk = ~clk;

  anc_ctrl #(
    .TAPS(256),
    .FIFO_DEPTH(4),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .smp_valid         (smp_valid),
    .x_smp             (x_smp),
    .e_smp             (e_smp),
    .mu                (mu),
    .adapt_en          (adapt_en),
    .a_bias            (a_bias),
    .clr_err           (clr_err),
    .fir_x_in          (fir_x_in),
    .fir_a_in          (fir_a_in),
    .fir_weight_adjust (fir_weight_adjust),
    .fir_go            (fir_go),
    .fir_done          (fir_done),
    .fir_out_sample    (fir_out_sample),
    .fir_out_valid     (fir_out_valid),
    .y_out             (y_out),
    .y_valid           (y_valid),
    .busy              (busy),
    .overrun           (overrun),
    .timeout           (timeout)
  );

  // FIR responder: answers fir_x_in ^ 16'h5A5A, fir_lat cycles after fir_go.
  always @(negedge clk) begin
    mdl_done  = 1'b0;
    mdl_valid = 1'b0;
    if (rst) begin
      mdl_cnt = 0;
    end else begin
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          mdl_done   = 1'b1;
          mdl_valid  = 1'b1;
          mdl_sample = fir_x_in ^ 16'h5A5A;
        end
      end
      if (fir_go && mdl_en) mdl_cnt = fir_lat;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push_pair(input logic [15:0] x, input logic [15:0] e);
    x_smp     = x;
    e_smp     = e;
    smp_valid = 1'b1;
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] e;
    logic [15:0] mu;
    logic        en;
    logic [15:0] bias;
    logic [15:0] wadj;
  } vec_t;

  vec_t vecs[7];
  logic [15:0] ov_x[8];

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{16'h4000, 16'h2000, 16'h4000, 1'b1, 16'h0100, 16'hF000};
    vecs[1] = '{16'h1111, 16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h8000};
    vecs[2] = '{16'h2222, 16'h8000, 16'h8000, 1'b0, 16'hFFFF, 16'h0000};
    vecs[3] = '{16'h1234, 16'hFFFF, 16'h4000, 1'b1, 16'h0042, 16'h0001};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h8000, 16'h8002};
    vecs[5] = '{16'h8000, 16'h0001, 16'h0001, 1'b1, 16'h7FFF, 16'h0000};
    vecs[6] = '{16'hC3C3, 16'h8000, 16'h7FFF, 1'b1, 16'h1357, 16'h7FFF};
    ov_x = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h0A06, 16'h0A07};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {15'd0, busy}, 16'h0);
    check("rst_fir_go", {15'd0, fir_go}, 16'h0);
    check("rst_y_valid", {15'd0, y_valid}, 16'h0);
    check("rst_flags", {14'd0, overrun, timeout}, 16'h0);
    check("rst_fir_x_in", fir_x_in, 16'h0);
    check("rst_wadj", fir_weight_adjust, 16'h0);
    check("rst_y_out", y_out, 16'h0);

    // Table: operand formation, 2-cycle issue latency, single go pulse, result path.
    mdl_en  = 1'b1;
    fir_lat = 3;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mu       = vecs[i].mu;
      adapt_en = vecs[i].en;
      a_bias   = vecs[i].bias;
      push_pair(vecs[i].x, vecs[i].e);
      @(negedge clk);
      smp_valid = 1'b0;
      check("go_early", {15'd0, fir_go}, 16'h0);
      @(negedge clk);
      check("go_latency", {15'd0, fir_go}, 16'h1);
      check("wadj", fir_weight_adjust, vecs[i].wadj);
      check("x_in", fir_x_in, vecs[i].x);
      check("a_in", fir_a_in, vecs[i].bias);
      mu       = 16'h0000;
      adapt_en = ~vecs[i].en;
      a_bias   = 16'h0000;
      @(negedge clk);
      check("go_single", {15'd0, fir_go}, 16'h0);
      check("wadj_stable", fir_weight_adjust, vecs[i].wadj);
      check("a_in_stable", fir_a_in, vecs[i].bias);
      begin
        int c;
        for (c = 0; c < 50 && !y_valid; c++) @(negedge clk);
        check("y_wait", {15'd0, y_valid}, 16'h1);
        check("y_out", y_out, vecs[i].x ^ 16'h5A5A);
      end
    end

    // Overrun: five strobes during WAIT, then a same-cycle clr_err, then clear.
    @(negedge clk);
    fir_lat = 30;
    push_pair(ov_x[0], 16'h0);
    @(negedge clk);
    smp_valid = 1'b0;
    @(negedge clk);
    check("ov_go", {15'd0, fir_go}, 16'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) check("ov_before_5th", {15'd0, overrun}, 16'h0);
      push_pair(ov_x[k], 16'h0);
    end
    @(negedge clk);
    check("ov_set", {15'd0, overrun}, 16'h1);
    push_pair(ov_x[6], 16'h0);
    clr_err = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    check("ov_set_wins", {15'd0, overrun}, 16'h1);
    @(negedge clk);
    clr_err = 1'b0;
    check("ov_cleared", {15'd0, overrun}, 16'h0);
    begin
      logic [15:0] exp_x[6];
      int got;
      bit pushed;
      exp_x = '{ov_x[0], ov_x[1], ov_x[2], ov_x[3], ov_x[4], ov_x[7]};
      got = 0;
      pushed = 1'b0;
      for (int c = 0; c < 2000 && got < 6; c++) begin
        @(negedge clk);
        smp_valid = 1'b0;
        if (y_valid) begin
          check("ov_order", y_out, exp_x[got] ^ 16'h5A5A);
          got++;
        end
        if (fir_go && got == 1 && !pushed) begin
          push_pair(ov_x[7], 16'h0);
          pushed = 1'b1;
        end
      end
      check("ov_count", 16'(got), 16'd6);
      check("full_push_pop_no_ov", {15'd0, overrun}, 16'h0);
      repeat (40) @(negedge clk);
      check("ov_no_extra", {14'd0, y_valid, busy}, 16'h0);
    end

    // Timeout: withheld done, next pair issues, clr_err, then done without valid.
    mdl_en = 1'b0;
    push_pair(16'h0B01, 16'h0);
    @(negedge clk);
    push_pair(16'h0B02, 16'h0);
    @(negedge clk);
    smp_valid = 1'b0;
    check("to_go", {15'd0, fir_go}, 16'h1);
    begin
      int yv;
      yv = 0;
      for (int c = 1; c < TIMEOUT; c++) begin
        @(negedge clk);
        if (y_valid) yv++;
      end
      check("to_not_early", {15'd0, timeout}, 16'h0);
      check("to_busy_before", {15'd0, busy}, 16'h1);
      @(negedge clk);
      if (y_valid) yv++;
      check("to_set", {15'd0, timeout}, 16'h1);
      check("to_idle", {15'd0, busy}, 16'h0);
      check("to_no_y", 16'(yv), 16'd0);
    end
    @(negedge clk);
    check("to_next_go", {15'd0, fir_go}, 16'h1);
    check("to_next_x", fir_x_in, 16'h0B02);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("to_cleared", {15'd0, timeout}, 16'h0);
    man_done  = 1'b1;
    man_valid = 1'b0;
    @(negedge clk);
    man_done = 1'b0;
    check("novalid_idle", {15'd0, busy}, 16'h0);
    check("novalid_no_y", {15'd0, y_valid}, 16'h0);
    @(negedge clk);
    check("novalid_no_y2", {15'd0, y_valid}, 16'h0);

    // Manual done with a known sample, then reset mid-job and a stray done.
    push_pair(16'h0C01, 16'h0);
    @(negedge clk);
    smp_valid = 1'b0;
    @(negedge clk);
    check("man_go", {15'd0, fir_go}, 16'h1);
    @(negedge clk);
    @(negedge clk);
    check("man_no_y_yet", {15'd0, y_valid}, 16'h0);
    man_done   = 1'b1;
    man_valid  = 1'b1;
    man_sample = 16'h1234;
    @(negedge clk);
    man_done = 1'b0;
    check("man_y_valid", {15'd0, y_valid}, 16'h1);
    check("man_y_out", y_out, 16'h1234);
    @(negedge clk);
    check("man_y_single", {15'd0, y_valid}, 16'h0);
    check("man_idle", {15'd0, busy}, 16'h0);

    push_pair(16'h0D01, 16'h0);
    @(negedge clk);
    smp_valid = 1'b0;
    @(negedge clk);
    check("rj_go", {15'd0, fir_go}, 16'h1);
    @(negedge clk);
    @(negedge clk);
    check("rj_busy", {15'd0, busy}, 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rj_busy_cleared", {15'd0, busy}, 16'h0);
    check("rj_x_zero", fir_x_in, 16'h0);
    @(negedge clk);
    man_done   = 1'b1;
    man_valid  = 1'b1;
    man_sample = 16'h7777;
    @(negedge clk);
    man_done = 1'b0;
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (y_valid || busy || fir_go) bad++;
        @(negedge clk);
      end
      check("rj_stray_ignored", 16'(bad), 16'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
